multicycle_divider_32: RTL



---
 rtl/div_defs.sv | 23 ++
 rtl/carryAheadAdder_32.sv | 44 ++++
 rtl/multicycle_divider_32.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/div_defs.sv
// Shared definitions for the iterative 32-bit divider: widths, FSM states,
// the divide-by-zero quotient and a two's-complement negation helper.
package div_defs;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  // Plain ~x+1 negation; kept behavioural so it never becomes a second adder instance
  function automatic logic [DIV_WIDTH-1:0] twosNegate(input logic [DIV_WIDTH-1:0] x);
    return ~x + DIV_WIDTH'(1);
  endfunction

endpackage

// File: rtl/carryAheadAdder_32.sv
// 32-bit adder built from eight 4-bit carry-lookahead groups; the group
// carries are chained so each group resolves its internal carries in parallel.
module carryAheadAdder_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [31:0] w_gen;
  logic [31:0] w_prop;

  assign w_gen  = i_a & i_b;
  assign w_prop = i_a ^ i_b;

  // Resolve each 4-bit group's carries from its generate/propagate terms and the incoming group carry
  always_comb begin
    logic       w_groupCarry;
    logic [3:0] w_g4;
    logic [3:0] w_p4;
    logic [4:0] w_c4;
    w_groupCarry = i_cin;
    o_sum        = '0;
    w_g4         = '0;
    w_p4         = '0;
    w_c4         = '0;
    for (int grp = 0; grp < 8; grp++) begin
      w_g4    = w_gen[grp*4 +: 4];
      w_p4    = w_prop[grp*4 +: 4];
      w_c4[0] = w_groupCarry;
      w_c4[1] = w_g4[0] | (w_p4[0] & w_c4[0]);
      w_c4[2] = w_g4[1] | (w_p4[1] & w_g4[0]) | (w_p4[1] & w_p4[0] & w_c4[0]);
      w_c4[3] = w_g4[2] | (w_p4[2] & w_g4[1]) | (w_p4[2] & w_p4[1] & w_g4[0])
              | (w_p4[2] & w_p4[1] & w_p4[0] & w_c4[0]);
      w_c4[4] = w_g4[3] | (w_p4[3] & w_g4[2]) | (w_p4[3] & w_p4[2] & w_g4[1])
              | (w_p4[3] & w_p4[2] & w_p4[1] & w_g4[0]) | ((&w_p4) & w_c4[0]);
      o_sum[grp*4 +: 4] = w_p4 ^ w_c4[3:0];
      w_groupCarry      = w_c4[4];
    end
    o_cout = w_groupCarry;
  end

endmodule

// File: rtl/multicycle_divider_32.sv
// Iterative signed/unsigned 32-bit divider for the EX stage. A restoring
// shift-subtract loop runs one quotient bit per cycle, then a fix-up cycle
// applies the result signs. Divide-by-zero short-circuits straight to DONE.
module multicycle_divider_32
  import div_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = DIV_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_t r_state;
  div_state_t w_nextState;

  logic [WIDTH-1:0]     r_R;
  logic [WIDTH-1:0]     r_Q;
  logic [WIDTH-1:0]     r_D;
  logic                 r_qNeg;
  logic                 r_rNeg;
  logic [DIV_CNT_W-1:0] r_count;
  logic                 r_divByZero;
  logic [WIDTH-1:0]     r_quotient;
  logic [WIDTH-1:0]     r_remainder;

  logic             w_aNeg;
  logic             w_bNeg;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic             w_divisorZero;
  logic [WIDTH-1:0] w_shiftR;
  logic             w_rMsb;
  logic [WIDTH-1:0] w_trial;
  logic             w_trialCout;
  logic             w_success;
  logic             w_lastIter;

  // Operand magnitudes are only taken for signed requests with a negative MSB
  assign w_aNeg        = signed_op & dividend[WIDTH-1];
  assign w_bNeg        = signed_op & divisor[WIDTH-1];
  assign w_absA        = w_aNeg ? twosNegate(dividend) : dividend;
  assign w_absB        = w_bNeg ? twosNegate(divisor) : divisor;
  assign w_divisorZero = (divisor == '0);

  // The partial remainder is effectively 33 bits wide: the bit shifted out of R
  // forces a successful subtraction even when the 32-bit trial has no carry out
  assign w_rMsb     = r_R[WIDTH-1];
  assign w_shiftR   = {r_R[WIDTH-2:0], r_Q[WIDTH-1]};
  assign w_success  = w_rMsb | w_trialCout;
  assign w_lastIter = (r_count == DIV_CNT_W'(ITER - 1));

  carryAheadAdder_32 u_trialAdder (
    .i_a    (w_shiftR),
    .i_b    (~r_D),
    .i_cin  (1'b1),
    .o_sum  (w_trial),
    .o_cout (w_trialCout)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= DIV_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic plus busy/ready decoded purely from the state register
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    ready       = 1'b0;
    case (r_state)
      DIV_IDLE: if (start) w_nextState = w_divisorZero ? DIV_DONE : DIV_RUN;
      DIV_RUN: begin
        busy = 1'b1;
        if (w_lastIter) w_nextState = DIV_FIX;
      end
      DIV_FIX: begin
        busy        = 1'b1;
        w_nextState = DIV_DONE;
      end
      DIV_DONE: begin
        ready       = 1'b1;
        w_nextState = DIV_IDLE;
      end
      default: w_nextState = DIV_IDLE;
    endcase
  end

  // Datapath: latch operands on an accepted start, iterate in RUN, publish results in FIX
  always_ff @(posedge clock) begin
    if (reset) begin
      r_R         <= '0;
      r_Q         <= '0;
      r_D         <= '0;
      r_qNeg      <= 1'b0;
      r_rNeg      <= 1'b0;
      r_count     <= '0;
      r_divByZero <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            if (w_divisorZero) begin
              r_quotient  <= DIV_ZERO_QUOT;
              r_remainder <= dividend;
              r_divByZero <= 1'b1;
            end else begin
              r_R     <= '0;
              r_Q     <= w_absA;
              r_D     <= w_absB;
              r_qNeg  <= w_aNeg ^ w_bNeg;
              r_rNeg  <= w_aNeg;
              r_count <= '0;
            end
          end
        end
        DIV_RUN: begin
          r_R     <= w_success ? w_trial : w_shiftR;
          r_Q     <= {r_Q[WIDTH-2:0], w_success};
          r_count <= r_count + DIV_CNT_W'(1);
        end
        DIV_FIX: begin
          r_quotient  <= r_qNeg ? twosNegate(r_Q) : r_Q;
          r_remainder <= r_rNeg ? twosNegate(r_R) : r_R;
          r_divByZero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign div_by_zero = r_divByZero;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;

endmodule
